// File: rtl/periph_pkg.sv
// Shared register-map constants and decode helper for the MMIO timer bank.
// Imported by the channel and the top; no build options live here.
package periph_pkg;

  localparam logic [31:0] OFF_TH       = 32'h00;
  localparam logic [31:0] OFF_TL       = 32'h04;
  localparam logic [31:0] OFF_TCON     = 32'h08;
  localparam logic [31:0] OFF_PRESC    = 32'h0C;
  localparam logic [31:0] OFF_CAP      = 32'h10;
  localparam logic [31:0] CH_STRIDE    = 32'h20;
  localparam logic [31:0] OFF_IRQ_STAT = 32'h100;

  localparam int unsigned TCON_EN   = 0;
  localparam int unsigned TCON_IE   = 1;
  localparam int unsigned TCON_PEND = 2;
  localparam int unsigned TCON_OS   = 3;

  typedef enum logic [2:0] {
    RegTh,
    RegTl,
    RegTcon,
    RegPresc,
    RegCap,
    RegNone
  } reg_sel_e;

  // Offset within one channel window; misaligned offsets map to nothing.
  function automatic reg_sel_e decode_reg(input logic [4:0] off);
    reg_sel_e sel;
    case ({27'b0, off})
      OFF_TH:    sel = RegTh;
      OFF_TL:    sel = RegTl;
      OFF_TCON:  sel = RegTcon;
      OFF_PRESC: sel = RegPresc;
      OFF_CAP:   sel = RegCap;
      default:   sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_timer_bank_if.sv
// CPU data-bus bundle for the timer bank: strobes, address, write data, combinational read data.
interface mmio_timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_channel.sv
// One reload timer channel: TH/TL/TCON/PRESC/CAP registers plus prescaler counter.
// Capture logic (2-flop sync + edge detect) is built only when TIMER_CAPTURE_EN is defined.
module timer_channel
  import periph_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               th_we_i,
  input  logic               tl_we_i,
  input  logic               tcon_we_i,
  input  logic               presc_we_i,
  input  logic               cap_we_i,
  input  logic               pend_clr_i,
  input  logic [31:0]        wdata_i,
  input  logic               cap_i,
  output logic [CNT_W-1:0]   th_o,
  output logic [CNT_W-1:0]   tl_o,
  output logic [CNT_W-1:0]   cap_o,
  output logic [PRESC_W-1:0] presc_o,
  output logic [3:0]         tcon_o,
  output logic               pend_o,
  output logic               irq_o
);

  logic [CNT_W-1:0]   th_q, th_d, tl_q, tl_d;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic               en_q, en_d, ie_q, ie_d, pend_q, pend_d, os_q, os_d;
  logic               tick, ovf, pend_set;

  assign tick     = en_q && (pcnt_q == presc_q);
  assign ovf      = tick && (tl_q == '1);
  // A CPU write to TL in the overflow cycle suppresses reload side effects.
  assign pend_set = ovf && ie_q && !tl_we_i;

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    en_d    = en_q;
    ie_d    = ie_q;
    os_d    = os_q;
    pend_d  = pend_q;

    if (th_we_i) th_d = wdata_i[CNT_W-1:0];

    if (presc_we_i) begin
      presc_d = wdata_i[PRESC_W-1:0];
      pcnt_d  = '0;
    end else if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    if (tl_we_i)   tl_d = wdata_i[CNT_W-1:0];
    else if (tick) tl_d = ovf ? th_q : tl_q + 1'b1;

    if (tcon_we_i) begin
      en_d = wdata_i[TCON_EN];
      ie_d = wdata_i[TCON_IE];
      os_d = wdata_i[TCON_OS];
    end else if (ovf && os_q && !tl_we_i) begin
      en_d = 1'b0;
    end

    // Set beats clear when both land in the same cycle.
    if (pend_set)        pend_d = 1'b1;
    else if (pend_clr_i) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      os_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      os_q    <= os_d;
      pend_q  <= pend_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cap_q, cap_d;

  always_comb begin
    sync_d = {sync_q[1:0], cap_i};
    cap_d  = cap_q;
    // sync_q[1] is the synchronised level, sync_q[2] its previous value.
    if (sync_q[1] && !sync_q[2]) cap_d = tl_q;
    else if (cap_we_i)           cap_d = wdata_i[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cap_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cap_q  <= cap_d;
    end
  end

  assign cap_o = cap_q;
`else
  logic unused_cap;
  assign unused_cap = cap_i ^ cap_we_i;
  assign cap_o      = '0;
`endif

  always_comb begin
    tcon_o            = '0;
    tcon_o[TCON_EN]   = en_q;
    tcon_o[TCON_IE]   = ie_q;
    tcon_o[TCON_PEND] = pend_q;
    tcon_o[TCON_OS]   = os_q;
  end

  assign th_o    = th_q;
  assign tl_o    = tl_q;
  assign presc_o = presc_q;
  assign pend_o  = pend_q;
  assign irq_o   = pend_q && ie_q;

endmodule

// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of NUM_TIMERS reload timers: address decode, read mux, IRQ_STAT, irqout.
// Optional capture inputs are enabled by defining TIMER_CAPTURE_EN.
module mmio_timer_bank
  import periph_pkg::*;
#(
  parameter int unsigned NUM_TIMERS = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PRESC_W    = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_timer_bank_if.slave      bus,
  input  logic [NUM_TIMERS-1:0] cap_in,
  output logic [NUM_TIMERS-1:0] irq,
  output logic                  irqout
);

  logic [NUM_TIMERS-1:0]       pend;
  logic [NUM_TIMERS-1:0][31:0] ch_rdata;
  logic                        stat_hit, stat_we;

  assign stat_hit = (bus.addr - BASE_ADDR) == OFF_IRQ_STAT;
  assign stat_we  = bus.wr && stat_hit;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    logic [31:0]        ch_off;
    reg_sel_e           sel;
    logic [CNT_W-1:0]   th, tl, cap;
    logic [PRESC_W-1:0] presc;
    logic [3:0]         tcon;
    logic               pend_clr;
    logic [31:0]        rdata_ch;

    assign ch_off   = bus.addr - (BASE_ADDR + CH_STRIDE * 32'(i));
    assign sel      = (ch_off < CH_STRIDE) ? decode_reg(ch_off[4:0]) : RegNone;
    assign pend_clr = (bus.wr && (sel == RegTcon) && bus.wdata[TCON_PEND])
                   || (stat_we && bus.wdata[i]);

    timer_channel #(
      .CNT_W  (CNT_W),
      .PRESC_W(PRESC_W)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .th_we_i   (bus.wr && (sel == RegTh)),
      .tl_we_i   (bus.wr && (sel == RegTl)),
      .tcon_we_i (bus.wr && (sel == RegTcon)),
      .presc_we_i(bus.wr && (sel == RegPresc)),
      .cap_we_i  (bus.wr && (sel == RegCap)),
      .pend_clr_i(pend_clr),
      .wdata_i   (bus.wdata),
      .cap_i     (cap_in[i]),
      .th_o      (th),
      .tl_o      (tl),
      .cap_o     (cap),
      .presc_o   (presc),
      .tcon_o    (tcon),
      .pend_o    (pend[i]),
      .irq_o     (irq[i])
    );

    always_comb begin
      rdata_ch = '0;
      case (sel)
        RegTh:    rdata_ch = 32'(th);
        RegTl:    rdata_ch = 32'(tl);
        RegTcon:  rdata_ch = 32'(tcon);
        RegPresc: rdata_ch = 32'(presc);
        RegCap:   rdata_ch = 32'(cap);
        default:  rdata_ch = '0;
      endcase
    end

    assign ch_rdata[i] = rdata_ch;
  end

  // Channel windows and IRQ_STAT never overlap, so OR-ing the hits is a mux.
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (stat_hit) bus.rdata = 32'(pend);
      for (int i = 0; i < NUM_TIMERS; i++) bus.rdata = bus.rdata | ch_rdata[i];
    end
  end

  assign irqout = |irq;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Self-checking bench for mmio_timer_bank: directed scenarios plus randomized register traffic
// checked against a behavioural register-map model. Covers TIMER_CAPTURE_EN in either build.
module tb_mmio_timer_bank;

  localparam int          NT   = 4;
  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [31:0] STAT = BASE + 32'h100;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] cap_in;
  logic [NT-1:0] irq;
  logic          irqout;

  mmio_timer_bank_if bus ();

  mmio_timer_bank #(
    .NUM_TIMERS(NT),
    .CNT_W     (32),
    .PRESC_W   (8),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .cap_in(cap_in),
    .irq   (irq),
    .irqout(irqout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]   m_th[NT], m_tl[NT], m_cap[NT];
  logic [7:0]    m_presc[NT], m_pcnt[NT];
  logic [NT-1:0] m_en, m_ie, m_pend, m_os;

  function automatic logic [31:0] ca(input int ch, input logic [31:0] off);
    return BASE + 32'(ch * 32) + off;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NT; c++) begin
      m_th[c] = '0; m_tl[c] = '0; m_cap[c] = '0; m_presc[c] = '0; m_pcnt[c] = '0;
    end
    m_en = '0; m_ie = '0; m_pend = '0; m_os = '0;
  endtask

  // Advances the model by one clock using the bus inputs currently presented.
  task automatic model_step();
    logic [31:0] off, coff;
    logic w, wth, wtl, wtc, wpr, wcap, wst, tick, ovf, set, clr;
    off = bus.addr - BASE;
    wst = bus.wr && (off == 32'h100);
    for (int c = 0; c < NT; c++) begin
      coff = off - 32'(c * 32);
      w    = bus.wr && (coff < 32'd32);
      wth  = w && (coff == 32'h00);
      wtl  = w && (coff == 32'h04);
      wtc  = w && (coff == 32'h08);
      wpr  = w && (coff == 32'h0C);
      wcap = w && (coff == 32'h10);
      tick = m_en[c] && (m_pcnt[c] == m_presc[c]);
      ovf  = tick && (m_tl[c] == 32'hFFFF_FFFF);
      set  = ovf && m_ie[c] && !wtl;
      clr  = (wtc && bus.wdata[2]) || (wst && bus.wdata[c]);
      if (wpr) begin
        m_presc[c] = bus.wdata[7:0];
        m_pcnt[c]  = 8'd0;
      end else if (m_en[c]) begin
        m_pcnt[c] = tick ? 8'd0 : m_pcnt[c] + 8'd1;
      end
      if (wtl)       m_tl[c] = bus.wdata;
      else if (tick) m_tl[c] = ovf ? m_th[c] : m_tl[c] + 32'd1;
      if (wth) m_th[c] = bus.wdata;
      if (set)      m_pend[c] = 1'b1;
      else if (clr) m_pend[c] = 1'b0;
      if (wtc) begin
        m_en[c] = bus.wdata[0];
        m_ie[c] = bus.wdata[1];
        m_os[c] = bus.wdata[3];
      end else if (ovf && m_os[c] && !wtl) begin
        m_en[c] = 1'b0;
      end
`ifdef TIMER_CAPTURE_EN
      if (wcap) m_cap[c] = bus.wdata;
`else
      if (wcap) m_cap[c] = '0;
`endif
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    int          c;
    off = a - BASE;
    if (off == 32'h100) return {28'b0, m_pend};
    if (off >= 32'(NT * 32)) return '0;
    c = int'(off >> 5);
    case (off[4:0])
      5'h00:   return m_th[c];
      5'h04:   return m_tl[c];
      5'h08:   return {28'b0, m_os[c], m_pend[c], m_ie[c], m_en[c]};
      5'h0C:   return {24'b0, m_presc[c]};
      5'h10:   return m_cap[c];
      default: return '0;
    endcase
  endfunction

  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    do_cycle();
    bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.rd = 1'b1; bus.addr = a;
    #1;
    d = bus.rdata;
    bus.rd = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; cap_in = '0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    bus_read(ca(0, 32'h04), d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_tl: got %h want %h", d, 32'h0); end
    bus_read(ca(0, 32'h08), d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_tcon: got %h want %h", d, 32'h0); end
    n_cmp++; if ({irqout, irq} !== 5'b0) begin
      n_err++; $display("FAIL reset_irq: got %b want %b", {irqout, irq}, 5'b0);
    end
    reset = 1'b0;
    do_cycle();
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    bus_write(ca(0, 32'h00), 32'hFFFF_FFF0);
    bus_write(ca(0, 32'h04), 32'hFFFF_FFFE);
    bus_write(ca(0, 32'h0C), 32'h0);
    bus_write(ca(0, 32'h08), 32'h3);
    do_cycle();
    bus_read(ca(0, 32'h04), d);
    n_cmp++; if (d !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL ovf_pre_tl: got %h want %h", d, 32'hFFFF_FFFF);
    end
    n_cmp++; if (irqout !== 1'b0) begin n_err++; $display("FAIL ovf_pre_irqout: got %b want 0", irqout); end
    do_cycle();
    bus_read(ca(0, 32'h04), d);
    n_cmp++; if (d !== 32'hFFFF_FFF0) begin
      n_err++; $display("FAIL ovf_reload_tl: got %h want %h", d, 32'hFFFF_FFF0);
    end
    bus_read(ca(0, 32'h08), d);
    n_cmp++; if (d !== 32'h7) begin n_err++; $display("FAIL ovf_tcon: got %h want %h", d, 32'h7); end
    n_cmp++; if (irqout !== 1'b1 || irq !== 4'b0001) begin
      n_err++; $display("FAIL ovf_irq: got %b/%b want 1/0001", irqout, irq);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    #2;
    reset = 1'b1;
    bus_read(ca(0, 32'h04), d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL async_rst_tl: got %h want %h", d, 32'h0); end
    bus_read(ca(0, 32'h08), d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL async_rst_tcon: got %h want %h", d, 32'h0); end
    n_cmp++; if (irqout !== 1'b0) begin n_err++; $display("FAIL async_rst_irqout: got %b want 0", irqout); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_prescaler();
    logic [31:0] d;
    bus_write(ca(1, 32'h0C), 32'h3);
    bus_write(ca(1, 32'h04), 32'h0);
    bus_write(ca(1, 32'h08), 32'h1);
    repeat (19) do_cycle();
    bus_read(ca(1, 32'h04), d);
    n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL presc_tl19: got %0d want 4", d); end
    do_cycle();
    bus_read(ca(1, 32'h04), d);
    n_cmp++; if (d !== 32'd5) begin n_err++; $display("FAIL presc_tl20: got %0d want 5", d); end
    bus_write(ca(1, 32'h08), 32'h0);
    repeat (8) do_cycle();
    bus_read(ca(1, 32'h04), d);
    n_cmp++; if (d !== 32'd5) begin n_err++; $display("FAIL presc_freeze: got %0d want 5", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    bus_write(ca(2, 32'h00), 32'h1234);
    bus_write(ca(2, 32'h0C), 32'h0);
    bus_write(ca(2, 32'h04), 32'hFFFF_FFFF);
    bus_write(ca(2, 32'h08), 32'hB);
    do_cycle();
    bus_read(ca(2, 32'h08), d);
    n_cmp++; if (d !== 32'hE) begin n_err++; $display("FAIL oneshot_tcon: got %h want %h", d, 32'hE); end
    bus_read(ca(2, 32'h04), d);
    n_cmp++; if (d !== 32'h1234) begin n_err++; $display("FAIL oneshot_reload: got %h want %h", d, 32'h1234); end
    repeat (5) do_cycle();
    bus_read(ca(2, 32'h04), d);
    n_cmp++; if (d !== 32'h1234) begin n_err++; $display("FAIL oneshot_hold: got %h want %h", d, 32'h1234); end
    n_cmp++; if (irq[2] !== 1'b1) begin n_err++; $display("FAIL oneshot_irq: got %b want 1", irq[2]); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    bus_write(ca(0, 32'h00), 32'h0);
    bus_write(ca(0, 32'h04), 32'hFFFF_FFFF);
    bus_write(ca(0, 32'h0C), 32'h0);
    bus_write(ca(0, 32'h08), 32'h3);
    bus_write(STAT, 32'h1);
    bus_read(STAT, d);
    n_cmp++; if (d !== 32'h5) begin n_err++; $display("FAIL w1c_set_wins: got %h want %h", d, 32'h5); end
    n_cmp++; if (irq[0] !== 1'b1) begin n_err++; $display("FAIL w1c_irq_held: got %b want 1", irq[0]); end
    bus_write(STAT, 32'h1);
    n_cmp++; if (irq[0] !== 1'b0) begin n_err++; $display("FAIL w1c_irq_drop: got %b want 0", irq[0]); end
    bus_read(STAT, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL w1c_cleared: got %h want %h", d, 32'h4); end
    bus_write(ca(2, 32'h08), 32'h8);
    n_cmp++; if (irq !== 4'b0000 || irqout !== 1'b0) begin
      n_err++; $display("FAIL ie_off_irq: got %b/%b want 0000/0", irq, irqout);
    end
    bus_read(STAT, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL ie_off_pend: got %h want %h", d, 32'h4); end
  endtask

  task automatic test_capture();
    logic [31:0] d, exp_cap;
    bus_write(ca(3, 32'h0C), 32'h0);
    bus_write(ca(3, 32'h04), 32'h100);
    bus_write(ca(3, 32'h08), 32'h1);
    cap_in[3] = 1'b1;
    do_cycle();
    do_cycle();
    exp_cap = m_tl[3];
    do_cycle();
`ifdef TIMER_CAPTURE_EN
    m_cap[3] = exp_cap;
`else
    exp_cap = 32'h0;
`endif
    cap_in[3] = 1'b0;
    bus_read(ca(3, 32'h10), d);
    n_cmp++; if (d !== exp_cap) begin n_err++; $display("FAIL capture_val: got %h want %h", d, exp_cap); end
    repeat (4) do_cycle();
    bus_read(ca(3, 32'h10), d);
    n_cmp++; if (d !== exp_cap) begin n_err++; $display("FAIL capture_hold: got %h want %h", d, exp_cap); end
    bus_write(ca(3, 32'h10), 32'hDEAD_BEEF);
    bus_read(ca(3, 32'h10), d);
    n_cmp++; if (d !== model_read(ca(3, 32'h10))) begin
      n_err++; $display("FAIL capture_write: got %h want %h", d, model_read(ca(3, 32'h10)));
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [31:0] addrs[4];
    addrs[0] = ca(4, 32'h00); addrs[1] = ca(0, 32'h14);
    addrs[2] = BASE - 32'h4;  addrs[3] = STAT + 32'h4;
    for (int k = 0; k < 4; k++) begin
      bus_read(addrs[k], d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd%0d: got %h want 0", k, d); end
      if (k == 1) do_cycle();
    end
    do_cycle();
    bus.rd = 1'b0; bus.addr = ca(3, 32'h04);
    #1;
    n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rd_low_zero: got %h want 0", bus.rdata); end
    bus_write(ca(4, 32'h04), 32'h55);
    bus_read(ca(0, 32'h04), d);
    n_cmp++; if (d !== model_read(ca(0, 32'h04))) begin
      n_err++; $display("FAIL unmapped_wr: got %h want %h", d, model_read(ca(0, 32'h04)));
    end
  endtask

  task automatic test_random();
    logic [31:0] d, a, exp_d;
    logic [NT-1:0] exp_irq;
    int op, ch, rg;
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      ch = int'($urandom_range(0, 4));
      case (op)
        0: bus_write(ca(ch, 32'h00), $urandom);
        1: bus_write(ca(ch, 32'h04), 32'hFFFF_FFFF - 32'($urandom_range(0, 6)));
        2: bus_write(ca(ch, 32'h04), $urandom);
        3: bus_write(ca(ch, 32'h08), 32'($urandom_range(0, 15)));
        4: bus_write(ca(ch, 32'h0C), 32'($urandom_range(0, 3)));
        5: bus_write(STAT, 32'($urandom_range(0, 15)));
        6: bus_write(ca(ch, 32'h10), $urandom);
        default: do_cycle();
      endcase
      rg = int'($urandom_range(0, 5));
      a  = (rg == 5) ? STAT : ca(int'($urandom_range(0, 3)), 32'(rg * 4));
      bus_read(a, d);
      exp_d = model_read(a);
      n_cmp++; if (d !== exp_d) begin
        n_err++; $display("FAIL rand_rd it%0d addr %h: got %h want %h", it, a, d, exp_d);
      end
      exp_irq = m_pend & m_ie;
      n_cmp++; if (irq !== exp_irq || irqout !== |exp_irq) begin
        n_err++; $display("FAIL rand_irq it%0d: got %b/%b want %b/%b", it, irq, irqout,
                          exp_irq, |exp_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_async_reset();
    test_prescaler();
    test_oneshot();
    test_w1c();
    test_capture();
    test_unmapped();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
